// File: rtl/agree_branch_predictor.sv
// Agree predictor: BTB holds target and bias bit, PHT counters say whether to agree with that bias.
// Zero-latency combinational lookup; training on the rising edge from execute-stage resolution.
module agree_branch_predictor #(
   parameter int BTB_IDX_W = 6,
   parameter int PHT_IDX_W = 8,
   parameter int GHR_W     = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_pc_f,
   output logic        o_btb_hit_f,
   output logic        o_taken_f,
   output logic [31:0] o_predicted_pc_f,
   input  logic        i_update_e,
   input  logic [31:0] i_pc_e,
   input  logic        i_taken_actual_e,
   input  logic [31:0] i_target_e
);
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int PHT_N = 1 << PHT_IDX_W;
   localparam int TAG_W = 30 - BTB_IDX_W;

   logic [BTB_N-1:0]     btb_valid;
   logic [BTB_N-1:0]     btb_bias;
   logic [TAG_W-1:0]     btb_tag    [BTB_N];
   logic [31:0]          btb_target [BTB_N];
   logic [1:0]           pht        [PHT_N];
   logic [GHR_W-1:0]     ghr;
   logic [GHR_W-1:0]     ghr_next;
   logic [PHT_IDX_W-1:0] ghr_ext;

   logic [BTB_IDX_W-1:0] btb_idx_f;
   logic [TAG_W-1:0]     tag_f;
   logic [PHT_IDX_W-1:0] pht_idx_f;
   logic [BTB_IDX_W-1:0] btb_idx_e;
   logic [TAG_W-1:0]     tag_e;
   logic [PHT_IDX_W-1:0] pht_idx_e;
   logic                 hit_e;
   logic                 unused_pc_bits;

   assign unused_pc_bits = ^{i_pc_f[1:0], i_pc_e[1:0]};

   always_comb begin
      ghr_ext = '0;
      ghr_ext[GHR_W-1:0] = ghr;
      ghr_next = ghr << 1;
      ghr_next[0] = i_taken_actual_e;
   end

   assign btb_idx_f = i_pc_f[BTB_IDX_W+1:2];
   assign tag_f     = i_pc_f[31:BTB_IDX_W+2];
   assign pht_idx_f = i_pc_f[PHT_IDX_W+1:2] ^ ghr_ext;

   // Valid gates the tag compare, so never-written tag storage cannot produce a hit.
   assign o_btb_hit_f      = btb_valid[btb_idx_f] && (btb_tag[btb_idx_f] == tag_f);
   assign o_taken_f        = o_btb_hit_f &&
                             (pht[pht_idx_f][1] ? btb_bias[btb_idx_f] : ~btb_bias[btb_idx_f]);
   assign o_predicted_pc_f = o_taken_f ? btb_target[btb_idx_f] : i_pc_f + 32'd4;

   assign btb_idx_e = i_pc_e[BTB_IDX_W+1:2];
   assign tag_e     = i_pc_e[31:BTB_IDX_W+2];
   assign pht_idx_e = i_pc_e[PHT_IDX_W+1:2] ^ ghr_ext;
   assign hit_e     = btb_valid[btb_idx_e] && (btb_tag[btb_idx_e] == tag_e);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         btb_valid <= '0;
         ghr       <= '0;
         for (int i = 0; i < PHT_N; i++) begin
            pht[i] <= 2'b10;
         end
      end else if (i_update_e) begin
         ghr <= ghr_next;
         if (hit_e) begin
            if (i_taken_actual_e == btb_bias[btb_idx_e]) begin
               if (pht[pht_idx_e] != 2'b11) pht[pht_idx_e] <= pht[pht_idx_e] + 2'd1;
            end else begin
               if (pht[pht_idx_e] != 2'b00) pht[pht_idx_e] <= pht[pht_idx_e] - 2'd1;
            end
         end else begin
            btb_valid[btb_idx_e] <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset: it is only ever observed through a valid entry.
   always_ff @(posedge i_clk) begin
      if (i_update_e && i_rst_n) begin
         if (hit_e) begin
            if (i_taken_actual_e) btb_target[btb_idx_e] <= i_target_e;
         end else begin
            btb_tag[btb_idx_e]    <= tag_e;
            btb_target[btb_idx_e] <= i_target_e;
            btb_bias[btb_idx_e]   <= i_taken_actual_e;
         end
      end
   end
endmodule

// File: tb/tb_agree_branch_predictor.sv
// Bench for agree_branch_predictor: directed vector table, then a model-driven random phase.
module tb_agree_branch_predictor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_f;
   logic        btb_hit;
   logic        taken;
   logic [31:0] predicted_pc;
   logic        update_e;
   logic [31:0] pc_e;
   logic        taken_e;
   logic [31:0] target_e;

   agree_branch_predictor #(.BTB_IDX_W(6), .PHT_IDX_W(8), .GHR_W(8)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_pc_f           (pc_f),
      .o_btb_hit_f      (btb_hit),
      .o_taken_f        (taken),
      .o_predicted_pc_f (predicted_pc),
      .i_update_e       (update_e),
      .i_pc_e           (pc_e),
      .i_taken_actual_e (taken_e),
      .i_target_e       (target_e)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [31:0] pc_f;
      bit          upd;
      logic [31:0] pc_e;
      bit          tk;
      logic [31:0] tgt;
      bit          e_hit;
      bit          e_tk;
      logic [31:0] e_pred;
   } vec_t;

   typedef struct {
      bit          hit;
      bit          tk;
      logic [31:0] pred;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state, fixed at 64 BTB entries, 256 counters, 8-bit history.
   bit          m_valid [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   bit          m_bias  [64];
   int          m_pht   [256];
   int          m_ghr;

   function automatic vec_t mk(bit rst, logic [31:0] pf, bit upd, logic [31:0] pe, bit tk,
                               logic [31:0] tgt, bit h, bit t, logic [31:0] p);
      vec_t v;
      v.rst = rst; v.pc_f = pf; v.upd = upd; v.pc_e = pe; v.tk = tk; v.tgt = tgt;
      v.e_hit = h; v.e_tk = t; v.e_pred = p;
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 256; i++) m_pht[i] = 2;
      m_ghr = 0;
   endtask

   task automatic m_lookup(input logic [31:0] pc, output exp_t e);
      int bi;
      int pi;
      bi = int'((pc >> 2) & 32'h3F);
      pi = int'((pc >> 2) & 32'hFF) ^ m_ghr;
      e.hit  = m_valid[bi] && (m_tag[bi] == (pc >> 8));
      e.tk   = e.hit && ((m_pht[pi] >= 2) ? m_bias[bi] : !m_bias[bi]);
      e.pred = e.tk ? m_tgt[bi] : pc + 32'd4;
   endtask

   task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
      int bi;
      int pi;
      bi = int'((pc >> 2) & 32'h3F);
      pi = int'((pc >> 2) & 32'hFF) ^ m_ghr;
      if (m_valid[bi] && (m_tag[bi] == (pc >> 8))) begin
         if (tk) m_tgt[bi] = tgt;
         if (tk == m_bias[bi]) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
         else                  m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
      end else begin
         m_valid[bi] = 1'b1;
         m_tag[bi]   = pc >> 8;
         m_tgt[bi]   = tgt;
         m_bias[bi]  = tk;
      end
      m_ghr = ((m_ghr << 1) | int'(tk)) & 255;
   endtask

   task automatic check(input string name, input int n, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, n, act, req);
      end
   endtask

   // One cycle: drive after the edge, sample on the falling edge, training lands on the next rise.
   task automatic run_step(input vec_t v, input bit from_model, input int n);
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      rst_n    = !v.rst;
      pc_f     = v.pc_f;
      update_e = v.upd;
      pc_e     = v.pc_e;
      taken_e  = v.tk;
      target_e = v.tgt;
      if (v.rst) m_reset();
      if (from_model) m_lookup(v.pc_f, e);
      else begin
         e.hit = v.e_hit; e.tk = v.e_tk; e.pred = v.e_pred;
      end
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty step %0d", n);
      end else begin
         got = sb.pop_front();
         check("hit", n, {31'd0, btb_hit}, {31'd0, got.hit});
         check("taken", n, {31'd0, taken}, {31'd0, got.tk});
         check("predicted_pc", n, predicted_pc, got.pred);
      end
      if (!v.rst && v.upd) m_update(v.pc_e, v.tk, v.tgt);
   endtask

   vec_t        tbl [25];
   vec_t        rv;
   logic [31:0] pool [8];

   initial begin
      rst_n = 1'b0; pc_f = 32'h0; update_e = 1'b0; pc_e = 32'h0; taken_e = 1'b0; target_e = 32'h0;
      m_reset();

      tbl[0]  = mk(1, 32'h100,      0, 32'h0,    0, 32'h0,   0, 0, 32'h104);
      tbl[1]  = mk(0, 32'h100,      0, 32'h0,    0, 32'h0,   0, 0, 32'h104);
      tbl[2]  = mk(0, 32'hFFFFFFFC, 0, 32'h0,    0, 32'h0,   0, 0, 32'h0);
      tbl[3]  = mk(0, 32'h100,      1, 32'h100,  1, 32'h80,  0, 0, 32'h104);
      tbl[4]  = mk(0, 32'h100,      0, 32'h0,    0, 32'h0,   1, 1, 32'h80);
      tbl[5]  = mk(0, 32'h200,      1, 32'h200,  0, 32'h300, 0, 0, 32'h204);
      for (int i = 6; i <= 12; i++)
         tbl[i] = mk(0, 32'h200,    1, 32'h200,  0, 32'h300, 1, 0, 32'h204);
      tbl[13] = mk(0, 32'h100,      1, 32'h100,  0, 32'h104, 0, 0, 32'h104);
      tbl[14] = mk(0, 32'h100,      1, 32'h100,  0, 32'h104, 1, 0, 32'h104);
      tbl[15] = mk(0, 32'h100,      0, 32'h0,    0, 32'h0,   1, 0, 32'h104);
      tbl[16] = mk(0, 32'h1100,     1, 32'h1100, 0, 32'h40,  0, 0, 32'h1104);
      tbl[17] = mk(0, 32'h100,      0, 32'h0,    0, 32'h0,   0, 0, 32'h104);
      tbl[18] = mk(0, 32'h1100,     0, 32'h0,    0, 32'h0,   1, 0, 32'h1104);
      tbl[19] = mk(0, 32'h500,      1, 32'h500,  1, 32'h600, 0, 0, 32'h504);
      tbl[20] = mk(0, 32'h500,      0, 32'h0,    0, 32'h0,   1, 1, 32'h600);
      tbl[21] = mk(1, 32'h500,      1, 32'h500,  0, 32'h700, 0, 0, 32'h504);
      tbl[22] = mk(0, 32'h500,      0, 32'h0,    0, 32'h0,   0, 0, 32'h504);
      tbl[23] = mk(0, 32'h100,      1, 32'h100,  1, 32'h80,  0, 0, 32'h104);
      tbl[24] = mk(0, 32'h100,      0, 32'h0,    0, 32'h0,   1, 1, 32'h80);

      repeat (3) @(posedge clk);
      for (int i = 0; i < 25; i++) run_step(tbl[i], 1'b0, i);

      // Small PC pool forces aliasing, hits, counter saturation and disagree predictions.
      pool[0] = 32'h100;  pool[1] = 32'h200;  pool[2] = 32'h1100; pool[3] = 32'h500;
      pool[4] = 32'h104;  pool[5] = 32'h140;  pool[6] = 32'hFFFFFFFC; pool[7] = 32'h2100;
      for (int n = 0; n < 400; n++) begin
         rv.rst  = ($urandom_range(99) == 0);
         rv.pc_f = pool[$urandom_range(7)];
         rv.upd  = ($urandom_range(9) < 7);
         rv.pc_e = ($urandom_range(3) == 0) ? rv.pc_f : pool[$urandom_range(7)];
         rv.tk   = 1'($urandom_range(1));
         rv.tgt  = $urandom() & 32'hFFFFFFFC;
         rv.e_hit = 1'b0; rv.e_tk = 1'b0; rv.e_pred = 32'h0;
         run_step(rv, 1'b1, 100 + n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
